// File: rtl/tile_scheduler_if.sv
// Scheduler-facing bundle: CSR job control, DMA and core handshakes,
// tile indices and job status. The scheduler uses the slave view.
interface tile_scheduler_if #(
   parameter int CNT_W = 16
);
   logic              start_pulse;
   logic              abort_pulse;
   logic [31:0]       M, N, K;
   logic [31:0]       Tm, Tn, Tk;
   logic              wdma_start;
   logic              wdma_done;
   logic              adma_start;
   logic              adma_done;
   logic              tile_start;
   logic              tile_done;
   logic              acc_clear;
   logic              k_last;
   logic [CNT_W-1:0]  m_idx, n_idx, k_idx;
   logic              bank_sel;
   logic              busy;
   logic              done_pulse;
   logic              err_pulse;

   modport slave (
      input  start_pulse, abort_pulse, M, N, K, Tm, Tn, Tk,
             wdma_done, adma_done, tile_done,
      output wdma_start, adma_start, tile_start, acc_clear, k_last,
             m_idx, n_idx, k_idx, bank_sel, busy, done_pulse, err_pulse
   );

   modport master (
      output start_pulse, abort_pulse, M, N, K, Tm, Tn, Tk,
             wdma_done, adma_done, tile_done,
      input  wdma_start, adma_start, tile_start, acc_clear, k_last,
             m_idx, n_idx, k_idx, bank_sel, busy, done_pulse, err_pulse
   );
endinterface

// File: rtl/tile_scheduler.sv
// Tiled GEMM job sequencer: walks tiles in m -> n -> k order, launching
// both DMAs, waiting for both, then launching the core for each tile.
module tile_scheduler #(
   parameter int CNT_W = 16
) (
   input  logic            clk_gated,
   input  logic            rst_n,
   tile_scheduler_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, WAIT_LOAD, COMPUTE, WAIT_COMP} state_t;

   state_t            state;
   logic [31:0]       m_dim, n_dim, k_dim, tm, tn, tk;
   logic [31:0]       m_off, n_off, k_off;
   logic [CNT_W-1:0]  m_idx, n_idx, k_idx;
   logic              wdone_l, adone_l;
   logic              bank_sel, busy;
   logic              wdma_start, adma_start, tile_start, acc_clear, k_last;
   logic              done_pulse, err_pulse;

   logic              m_is_last, n_is_last, k_is_last, job_last;
   logic              dims_ok, w_ok, a_ok;

   // 33-bit compare so off+T cannot wrap; covers non-divisible dimensions
   assign m_is_last = ({1'b0, m_off} + {1'b0, tm}) >= {1'b0, m_dim};
   assign n_is_last = ({1'b0, n_off} + {1'b0, tn}) >= {1'b0, n_dim};
   assign k_is_last = ({1'b0, k_off} + {1'b0, tk}) >= {1'b0, k_dim};
   assign job_last  = m_is_last & n_is_last & k_is_last;

   assign dims_ok = (bus.M != '0) && (bus.N != '0) && (bus.K != '0) &&
                    (bus.Tm != '0) && (bus.Tn != '0) && (bus.Tk != '0);

   // a done arriving this cycle counts together with an earlier latched one
   assign w_ok = wdone_l | bus.wdma_done;
   assign a_ok = adone_l | bus.adma_done;

   // job FSM with registered pulse outputs, indices and offsets
   always_ff @(posedge clk_gated or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         {m_dim, n_dim, k_dim, tm, tn, tk} <= '0;
         {m_off, n_off, k_off} <= '0;
         m_idx      <= '0;
         n_idx      <= '0;
         k_idx      <= '0;
         wdone_l    <= 1'b0;
         adone_l    <= 1'b0;
         bank_sel   <= 1'b0;
         busy       <= 1'b0;
         wdma_start <= 1'b0;
         adma_start <= 1'b0;
         tile_start <= 1'b0;
         acc_clear  <= 1'b0;
         k_last     <= 1'b0;
         done_pulse <= 1'b0;
         err_pulse  <= 1'b0;
      end else begin
         wdma_start <= 1'b0;
         adma_start <= 1'b0;
         tile_start <= 1'b0;
         acc_clear  <= 1'b0;
         k_last     <= 1'b0;
         done_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         if (bus.abort_pulse) begin
            // abort dominates; in IDLE it only swallows a coincident start
            if (state != IDLE) begin
               state    <= IDLE;
               busy     <= 1'b0;
               {m_off, n_off, k_off} <= '0;
               m_idx    <= '0;
               n_idx    <= '0;
               k_idx    <= '0;
               bank_sel <= 1'b0;
               wdone_l  <= 1'b0;
               adone_l  <= 1'b0;
            end
         end else begin
            if (bus.start_pulse && state != IDLE)
               err_pulse <= 1'b1;
            case (state)
               IDLE: begin
                  if (bus.start_pulse) begin
                     if (dims_ok) begin
                        m_dim      <= bus.M;
                        n_dim      <= bus.N;
                        k_dim      <= bus.K;
                        tm         <= bus.Tm;
                        tn         <= bus.Tn;
                        tk         <= bus.Tk;
                        {m_off, n_off, k_off} <= '0;
                        m_idx      <= '0;
                        n_idx      <= '0;
                        k_idx      <= '0;
                        bank_sel   <= 1'b0;
                        busy       <= 1'b1;
                        wdma_start <= 1'b1;
                        adma_start <= 1'b1;
                        state      <= LOAD;
                     end else begin
                        err_pulse  <= 1'b1;
                     end
                  end
               end
               LOAD: begin
                  wdone_l <= 1'b0;
                  adone_l <= 1'b0;
                  state   <= WAIT_LOAD;
               end
               WAIT_LOAD: begin
                  if (bus.wdma_done) wdone_l <= 1'b1;
                  if (bus.adma_done) adone_l <= 1'b1;
                  if (w_ok && a_ok) begin
                     tile_start <= 1'b1;
                     acc_clear  <= (k_idx == '0);
                     k_last     <= k_is_last;
                     state      <= COMPUTE;
                  end
               end
               COMPUTE: state <= WAIT_COMP;
               WAIT_COMP: begin
                  if (bus.tile_done) begin
                     bank_sel <= ~bank_sel;
                     if (!k_is_last) begin
                        k_idx <= k_idx + CNT_W'(1);
                        k_off <= k_off + tk;
                     end else if (!n_is_last) begin
                        k_idx <= '0;
                        k_off <= '0;
                        n_idx <= n_idx + CNT_W'(1);
                        n_off <= n_off + tn;
                     end else if (!m_is_last) begin
                        k_idx <= '0;
                        k_off <= '0;
                        n_idx <= '0;
                        n_off <= '0;
                        m_idx <= m_idx + CNT_W'(1);
                        m_off <= m_off + tm;
                     end
                     if (job_last) begin
                        done_pulse <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                     end else begin
                        wdma_start <= 1'b1;
                        adma_start <= 1'b1;
                        state      <= LOAD;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.wdma_start = wdma_start;
   assign bus.adma_start = adma_start;
   assign bus.tile_start = tile_start;
   assign bus.acc_clear  = acc_clear;
   assign bus.k_last     = k_last;
   assign bus.m_idx      = m_idx;
   assign bus.n_idx      = n_idx;
   assign bus.k_idx      = k_idx;
   assign bus.bank_sel   = bank_sel;
   assign bus.busy       = busy;
   assign bus.done_pulse = done_pulse;
   assign bus.err_pulse  = err_pulse;
endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: table of jobs with a loop-nest model
// of the expected tile order, plus hand sequences for illegal starts.
module tb_tile_scheduler;
   logic clk_gated = 1'b0;
   logic rst_n     = 1'b0;
   always #5 clk_gated = ~clk_gated;

   tile_scheduler_if #(.CNT_W(16)) bus();
   tile_scheduler #(.CNT_W(16)) dut (.clk_gated(clk_gated), .rst_n(rst_n), .bus(bus));

   typedef struct {
      int m, n, k, tm, tn, tk;
      int dw, da;          // cycles into WAIT_LOAD at which each done arrives
      int stray;           // stray tile_done during WAIT_LOAD
      int busy_start;      // extra start during tile 0 compute
      int abort_tile;      // tile whose compute gets aborted, -1 for none
      int exp_tiles;       // hand-computed tile count
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;
   int cnt_w = 0, cnt_a = 0, cnt_t = 0, cnt_d = 0, cnt_e = 0;

   // pulse counters, one count per high cycle
   always @(posedge clk_gated) begin
      if (bus.wdma_start === 1'b1) cnt_w <= cnt_w + 1;
      if (bus.adma_start === 1'b1) cnt_a <= cnt_a + 1;
      if (bus.tile_start === 1'b1) cnt_t <= cnt_t + 1;
      if (bus.done_pulse === 1'b1) cnt_d <= cnt_d + 1;
      if (bus.err_pulse  === 1'b1) cnt_e <= cnt_e + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_job(input vec_t v);
      int nm, nn, nk, t, maxd, cd, total;
      int w0, a0, t0, d0, e0;
      bit aborted;
      nm = (v.m + v.tm - 1) / v.tm;
      nn = (v.n + v.tn - 1) / v.tn;
      nk = (v.k + v.tk - 1) / v.tk;
      total = nm * nn * nk;
      w0 = cnt_w; a0 = cnt_a; t0 = cnt_t; d0 = cnt_d; e0 = cnt_e;
      t = 0;
      aborted = 1'b0;
      @(negedge clk_gated);
      bus.M = v.m; bus.N = v.n; bus.K = v.k;
      bus.Tm = v.tm; bus.Tn = v.tn; bus.Tk = v.tk;
      bus.start_pulse = 1'b1;
      @(negedge clk_gated);
      bus.start_pulse = 1'b0;
      chk("busy_after_start", bus.busy, 1);
      for (int mi = 0; mi < nm; mi++)
         for (int ni = 0; ni < nn; ni++)
            for (int ki = 0; ki < nk; ki++) begin
               if (!aborted) begin
                  chk("wdma_start", bus.wdma_start, 1);
                  chk("adma_start", bus.adma_start, 1);
                  chk("m_idx", bus.m_idx, mi);
                  chk("n_idx", bus.n_idx, ni);
                  chk("k_idx", bus.k_idx, ki);
                  chk("bank_sel", bus.bank_sel, t % 2);
                  maxd = (v.dw > v.da) ? v.dw : v.da;
                  for (int i = 1; i <= maxd; i++) begin
                     @(negedge clk_gated);
                     bus.wdma_done = (i == v.dw);
                     bus.adma_done = (i == v.da);
                     bus.tile_done = (v.stray != 0) && (i == 1);
                  end
                  @(negedge clk_gated);
                  bus.wdma_done = 1'b0;
                  bus.adma_done = 1'b0;
                  bus.tile_done = 1'b0;
                  chk("tile_start", bus.tile_start, 1);
                  chk("tile_start_not_early", cnt_t - t0, t);
                  chk("acc_clear", bus.acc_clear, (ki == 0));
                  chk("k_last", bus.k_last, (ki == nk - 1));
                  if (v.abort_tile == t) begin
                     @(negedge clk_gated);
                     bus.abort_pulse = 1'b1;
                     @(negedge clk_gated);
                     bus.abort_pulse = 1'b0;
                     chk("abort_busy", bus.busy, 0);
                     chk("abort_done", bus.done_pulse, 0);
                     chk("abort_err", bus.err_pulse, 0);
                     chk("abort_m_idx", bus.m_idx, 0);
                     chk("abort_k_idx", bus.k_idx, 0);
                     chk("abort_bank", bus.bank_sel, 0);
                     repeat (3) @(negedge clk_gated);
                     chk("abort_no_done", cnt_d - d0, 0);
                     chk("abort_wdma_cnt", cnt_w - w0, v.abort_tile + 1);
                     aborted = 1'b1;
                  end else begin
                     cd = (v.busy_start != 0 && t == 0) ? 3 : 1;
                     for (int i = 1; i <= cd; i++) begin
                        @(negedge clk_gated);
                        if (v.busy_start != 0 && t == 0 && i == 2)
                           chk("busy_start_err", bus.err_pulse, 1);
                        bus.start_pulse = (v.busy_start != 0) && (t == 0) && (i == 1);
                        bus.tile_done   = (i == cd);
                     end
                     @(negedge clk_gated);
                     bus.tile_done = 1'b0;
                     bus.start_pulse = 1'b0;
                     if (t == total - 1) begin
                        chk("done_pulse", bus.done_pulse, 1);
                        chk("busy_at_done", bus.busy, 0);
                     end else begin
                        chk("busy_mid_job", bus.busy, 1);
                     end
                  end
                  t++;
               end
            end
      if (!aborted) begin
         @(negedge clk_gated);
         chk("wdma_count", cnt_w - w0, v.exp_tiles);
         chk("adma_count", cnt_a - a0, v.exp_tiles);
         chk("tile_count", cnt_t - t0, v.exp_tiles);
         chk("done_count", cnt_d - d0, 1);
         chk("err_count", cnt_e - e0, v.busy_start);
      end
   endtask

   vec_t vecs[7];
   int w_snap, e_snap;

   initial begin
      //          m  n  k  tm tn tk dw da st bs ab  tiles
      vecs[0] = '{ 8, 8, 8, 8, 8, 8, 2, 2, 0, 0, -1, 1};  // single tile, dones together
      vecs[1] = '{16, 8,24, 8, 8, 8, 3, 1, 0, 0, -1, 6};  // multi-tile m/k walk
      vecs[2] = '{10, 4, 4, 8, 4, 4, 1, 2, 0, 0, -1, 2};  // non-divisible M
      vecs[3] = '{ 4, 4, 4, 4, 4, 4, 6, 1, 1, 0, -1, 1};  // adma 5 cycles early, stray tile_done
      vecs[4] = '{ 8, 8,16, 8, 8, 8, 1, 1, 0, 1, -1, 2};  // start while busy
      vecs[5] = '{16, 8,24, 8, 8, 8, 2, 2, 0, 0,  3, 6};  // abort during tile 3
      vecs[6] = '{16, 8,24, 8, 8, 8, 1, 3, 0, 0, -1, 6};  // full rerun after abort

      bus.start_pulse = 1'b0; bus.abort_pulse = 1'b0;
      bus.M = 0; bus.N = 0; bus.K = 0; bus.Tm = 0; bus.Tn = 0; bus.Tk = 0;
      bus.wdma_done = 1'b0; bus.adma_done = 1'b0; bus.tile_done = 1'b0;

      @(negedge clk_gated);
      chk("rst_busy", bus.busy, 0);
      chk("rst_wdma_start", bus.wdma_start, 0);
      chk("rst_tile_start", bus.tile_start, 0);
      chk("rst_done", bus.done_pulse, 0);
      chk("rst_err", bus.err_pulse, 0);
      chk("rst_bank", bus.bank_sel, 0);
      chk("rst_m_idx", bus.m_idx, 0);
      chk("rst_acc_clear", bus.acc_clear, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_gated);

      for (int v = 0; v < 7; v++) run_job(vecs[v]);

      // zero tile size: rejected with err_pulse, no DMA activity
      w_snap = cnt_w;
      bus.M = 8; bus.N = 8; bus.K = 8; bus.Tm = 8; bus.Tn = 8; bus.Tk = 0;
      bus.start_pulse = 1'b1;
      @(negedge clk_gated);
      bus.start_pulse = 1'b0;
      chk("zero_tk_err", bus.err_pulse, 1);
      chk("zero_tk_busy", bus.busy, 0);
      chk("zero_tk_wdma", bus.wdma_start, 0);
      repeat (2) @(negedge clk_gated);
      chk("zero_tk_no_dma", cnt_w - w_snap, 0);
      chk("zero_tk_busy_later", bus.busy, 0);

      // abort together with start in IDLE: start dropped silently
      e_snap = cnt_e;
      bus.Tk = 8;
      bus.start_pulse = 1'b1;
      bus.abort_pulse = 1'b1;
      @(negedge clk_gated);
      bus.start_pulse = 1'b0;
      bus.abort_pulse = 1'b0;
      chk("abort_start_err", bus.err_pulse, 0);
      chk("abort_start_busy", bus.busy, 0);
      chk("abort_start_wdma", bus.wdma_start, 0);
      @(negedge clk_gated);
      chk("abort_start_err_cnt", cnt_e - e_snap, 0);

      // done pulses while idle must not wake the scheduler
      bus.wdma_done = 1'b1; bus.adma_done = 1'b1; bus.tile_done = 1'b1;
      @(negedge clk_gated);
      bus.wdma_done = 1'b0; bus.adma_done = 1'b0; bus.tile_done = 1'b0;
      @(negedge clk_gated);
      chk("idle_dones_tile_start", bus.tile_start, 0);
      chk("idle_dones_busy", bus.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/tile_scheduler.md
# tile_scheduler

Sequences a complete tiled GEMM job once the host CSR block issues a start pulse. It latches the problem dimensions (M, N, K) and tile sizes (Tm, Tn, Tk), and walks the tile loop nest in m → n → k order. For each tile it triggers the weight (BSR) DMA and the activation DMA, waits for both, then launches the core and waits for tile completion. It sits between the CSR block and the DMA engines and systolic core, and produces job-level busy, done and error indications.

## Interface
Parameters:
- CNT_W, 16, width of each tile-index counter (m_idx, n_idx, k_idx)

Ports:
- clk_gated  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_pulse  in  1  single-cycle job start
- abort_pulse  in  1  single-cycle job abort
- M, N, K  in  32 each  problem dimensions, sampled only on an accepted start
- Tm, Tn, Tk  in  32 each  tile sizes, sampled only on an accepted start
- wdma_start  out  1  single-cycle weight DMA start
- wdma_done  in  1  weight DMA completion pulse
- adma_start  out  1  single-cycle activation DMA start
- adma_done  in  1  activation DMA completion pulse
- tile_start  out  1  single-cycle core start
- tile_done  in  1  core tile-completion pulse
- acc_clear  out  1  qualifies tile_start; high when k_idx==0
- k_last  out  1  qualifies tile_start; high on the final k tile (write-back enable)
- m_idx, n_idx, k_idx  out  CNT_W each  current tile indices
- bank_sel  out  1  ping-pong buffer select for the current tile
- busy  out  1  job in progress
- done_pulse  out  1  single cycle, high on normal completion
- err_pulse  out  1  single cycle, high on a rejected start

## Operation
- States and transitions:
  - IDLE
    - An accepted start goes to LOAD.
    - A rejected start fires err_pulse and stays in IDLE.
  - LOAD
    - Fires wdma_start and adma_start in the same cycle.
    - Clears the per-DMA done latches.
    - Goes to WAIT_LOAD.
  - WAIT_LOAD
    - Latches wdma_done and adma_done independently.
    - Goes to COMPUTE once both latches are set, or when the final done arrives together with the earlier latch.
  - COMPUTE
    - Fires tile_start, with acc_clear and k_last valid in the same cycle.
    - Goes to WAIT_COMP.
  - WAIT_COMP
    - On tile_done, advances the indices and toggles bank_sel.
    - Goes to LOAD, or to IDLE with done_pulse if this was the final tile.
- Start acceptance:
  - Rejected when any of M, N, K, Tm, Tn, Tk is 0; err_pulse fires.
  - A start while busy is ignored and fires err_pulse; the running job is unaffected.
- Loop tracking:
  - Uses 32-bit offsets m_off, n_off and k_off.
  - A dimension is on its last tile when the 33-bit sum (off + T) ≥ dim. This handles non-divisible sizes: M=10 with Tm=8 gives 2 tiles.
- Index advance on tile_done:
  - If k is not last: increment k.
  - Else if n is not last: clear k, increment n.
  - Else if m is not last: clear k and n, increment m.
  - Else: the job is finished.
- Index counters wrap modulo 2^CNT_W. A tile count greater than 2^CNT_W in any dimension is unsupported.
- Abort:
  - From any state other than IDLE, the next state is IDLE and busy drops.
  - No done_pulse and no err_pulse.
  - Indices, offsets and bank_sel reset to 0.
  - The DMA engines and core handle their own abort.
- abort_pulse and start_pulse together in IDLE: abort wins and the start is dropped, with no err_pulse.
- wdma_done, adma_done and tile_done arriving outside their wait state are ignored.
- Mid-job reset: all state returns to reset values immediately (asynchronous reset).

## Timing
- Reset values:
  - Every output is 0, the state is IDLE, and all latched dimensions are 0.
  - bank_sel=0.
- All outputs are registered.
- Accepted start:
  - start_pulse is sampled at edge t.
  - busy=1 from cycle t+1.
  - wdma_start and adma_start are high in cycle t+1 only.
- Load to compute: when the later DMA done is sampled at edge e, tile_start is high in cycle e+1.
- End of a tile: tile_done is sampled at edge e.
  - Non-final tile: the new indices and bank_sel are visible in cycle e+1, and the DMA starts are high in cycle e+1.
  - Final tile: done_pulse is high in cycle e+1 and busy=0 in cycle e+1.
- Per-tile scheduling overhead is 2 cycles in addition to the DMA and core latencies.
- abort_pulse sampled at edge t: busy=0 and state=IDLE in cycle t+1. A new start is accepted at edge t+1.
- err_pulse is high in the cycle after the offending start_pulse.
- Clocking assumption: the clock gate must keep clk_gated running whenever busy=1 or a DMA/core done pulse is possible. The scheduler does not tolerate missed pulses.

## Test plan
- Single tile, M=N=K=8 and Tm=Tn=Tk=8:
  - Exactly one wdma_start/adma_start pair and one tile_start, with acc_clear=1 and k_last=1.
  - Indices (0,0,0); done_pulse once; busy low in the same cycle as done_pulse.
- Multi-tile, M=16, N=8, K=24, all tile sizes 8:
  - 6 tiles, in order (0,0,0) (0,0,1) (0,0,2) (1,0,0) (1,0,1) (1,0,2).
  - acc_clear only on k=0; k_last only on k=2; bank_sel alternates 0,1,0,1,0,1.
- Non-divisible, M=10, Tm=8, N=K=Tn=Tk=4: 2 tiles, m_idx 0 then 1, then done_pulse.
- Illegal starts:
  - Tk=0 then start: err_pulse in the next cycle, busy stays 0, no DMA start.
  - Start during a running job: err_pulse, and the job completes with the normal tile count.
- Skewed DMA dones:
  - adma_done 5 cycles before wdma_done: tile_start exactly 1 cycle after wdma_done.
  - Both dones in the same cycle: tile_start 1 cycle later.
  - A stray tile_done during WAIT_LOAD is ignored.
- Abort during WAIT_COMP of tile 3:
  - busy=0 next cycle, no done_pulse, indices and bank_sel return to 0.
  - A subsequent start runs the full job from (0,0,0).
